dmem_wb_slave: RTL and testbench
================================

// Module: dmem_wb_slave
// PURPOSE
//  Data-memory slave on the CPU data port; consumes STB_O/WE_O/DAT_ADR_O/DAT_O, returns ACK_I/DAT_I.
//  Single-port synchronous RAM behind a classic strobe/ack handshake.
//  Programmable wait states, so the CPU control unit's ack-stall path is exercised.
//  Sits directly downstream of the CPU top.
// PARAMETERS
//  ADDR_W       10  word-address width; depth = 2**ADDR_W 16-bit words
//  WAIT_STATES  1   extra cycles between request accept and ACK (0..15)
// PORTS
//  CLK_I   in   1   clock; all logic on rising edge
//  RST_I   in   1   synchronous reset, active-high
//  STB_I   in   1   request strobe from CPU (STB_O)
//  WE_I    in   1   1 = write, 0 = read (CPU WE_O)
//  ADR_I   in   16  word address (CPU DAT_ADR_O)
//  DAT_I   in   16  write data (CPU DAT_O)
//  DAT_O   out  16  read data to CPU DAT_I
//  ACK_O   out  1   one-cycle completion pulse to CPU ACK_I
//  ERR_O   out  1   present only with DMEM_ERR_EN; one-cycle error pulse
// BEHAVIOUR
//  Reset: state=IDLE, ACK_O=0, ERR_O=0, DAT_O=16'h0000, wait counter=0. RAM contents not cleared.
//  Reset mid-transaction: aborts at once. A write not yet in RESP is never committed. No ACK follows.
//  FSM states: IDLE, WAIT, RESP, HOLD.
//   IDLE: if STB_I=1, latch ADR_I/WE_I/DAT_I and load counter=WAIT_STATES.
//         Next state is WAIT, or RESP directly if WAIT_STATES=0.
//   WAIT: counter decrements each cycle; go to RESP in the cycle counter==1.
//         Total accept-to-ACK latency = WAIT_STATES+1 cycles.
//   RESP: ACK_O=1 for exactly this cycle.
//         Write: RAM[addr]<=latched data at this edge.
//         Read: DAT_O<=RAM[addr], valid in the same cycle ACK_O is high. Go to HOLD.
//   HOLD: wait for STB_I=0, then IDLE. One request produces exactly one ACK, even if STB_I stays high.
//         Back-to-back accesses need >=1 cycle with STB_I low.
//  Inputs are sampled only at accept. Changes on ADR_I/DAT_I/WE_I during WAIT/RESP/HOLD are ignored.
//  STB_I dropping during WAIT does not cancel the access; it completes and ACKs.
//  DAT_O holds the last read value until the next read's RESP; writes do not change DAT_O.
//  Address: RAM index = latched ADR_I[ADDR_W-1:0].
//  Read-during-write cannot occur (single outstanding request).
// CONFIGURATION
//  DMEM_ERR_EN undefined:
//   - ADR_I[15:ADDR_W] is ignored; addresses wrap modulo 2**ADDR_W.
//   - No ERR_O port.
//  DMEM_ERR_EN defined:
//   - ERR_O port exists.
//   - Latched ADR_I[15:ADDR_W]!=0 is out of range. In RESP, ERR_O=1 instead of ACK_O.
//   - Out-of-range write: RAM unchanged. Out-of-range read: DAT_O unchanged.
//   - In-range accesses behave identically to the undefined case. ERR_O reset value 0.
// TESTING
//  T1 reset: RST_I=1 2 cycles with STB_I=1 -> ACK_O=0, DAT_O=0000; first ACK only after RST_I=0 +
//     WAIT_STATES+1.
//  T2 write/read, WAIT_STATES=1: write 16'hBEEF @0x005 -> ACK 2 cycles after accept.
//     Read @0x005 -> DAT_O=BEEF in the ACK cycle.
//  T3 latency sweep: WAIT_STATES=0,3,15 -> ACK exactly 1,4,16 cycles after accept; ACK width 1.
//  T4 held strobe: STB_I high 10 cycles -> exactly one ACK. Drop STB_I 1 cycle, reassert -> second ACK.
//  T5 reset mid-op: write 16'h1234 @0x010 (old 16'h0000), WAIT_STATES=3, assert RST_I in WAIT ->
//     no ACK; read @0x010 -> 0000.
//  T6 range (ADDR_W=10): write 16'hA5A5 @0x0403.
//     Without DMEM_ERR_EN -> ACK, read @0x003 = A5A5.
//     With DMEM_ERR_EN -> ERR_O pulse, no ACK, RAM[0x003] unchanged.

Source files
------------

// File: rtl/dmem_wb_slave.sv
// ---------------------------------------------------------------------------
// dmem_wb_slave
//   Data-memory slave for the CPU data port. A single-port synchronous RAM of
//   2**ADDR_W 16-bit words sits behind a strobe/ack handshake. A programmable
//   number of wait states is inserted between request accept and ACK.
//
// Handshake (single outstanding request):
//   In IDLE a high STB_I is accepted and ADR_I/WE_I/DAT_I are latched. After
//   WAIT_STATES+1 cycles ACK_O pulses high for exactly one cycle. For reads,
//   DAT_O carries the data in that same cycle. The slave then holds until STB_I
//   is seen low before it accepts again. A strobe held high therefore gets
//   exactly one ACK. STB_I dropping after accept does not cancel the access.
//
// Parameters:
//   ADDR_W       word-address width (1..15); RAM depth = 2**ADDR_W
//   WAIT_STATES  extra cycles between accept and ACK (0..15)
//
// Ports:
//   CLK_I      clock, rising edge
//   RST_I      synchronous reset, active high; aborts any access in flight
//   STB_I      request strobe
//   WE_I       1 = write, 0 = read
//   ADR_I      16-bit word address; RAM index is ADR_I[ADDR_W-1:0]
//   DAT_I      write data
//   DAT_O      read data; holds the last read value until the next read
//   ACK_O      one-cycle completion pulse
//   ERR_O      one-cycle error pulse (exists only with DMEM_ERR_EN)
//   dbg_state  current FSM state (IDLE=0, WAIT=1, RESP=2, HOLD=3)
//
// Build option:
//   DMEM_ERR_EN  when defined, a latched address with any of ADR_I[15:ADDR_W]
//                set is out of range. Such an access answers with ERR_O
//                instead of ACK_O, leaves the RAM untouched (write), and
//                leaves DAT_O unchanged (read). When undefined, the upper
//                address bits are ignored and addresses wrap.
// ---------------------------------------------------------------------------
module dmem_wb_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [15:0] ADR_I,
    input  logic [15:0] DAT_I,
    output logic [15:0] DAT_O,
    output logic        ACK_O,
`ifdef DMEM_ERR_EN
    output logic        ERR_O,
`endif
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t state, state_next;

    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] adr_q;
    logic [15:0]       dat_q;

    logic [15:0] mem [2**ADDR_W];

    // The RAM is accessed on the edge that enters RESP. This makes read data
    // valid in the ACK cycle. With zero wait states that edge is also the
    // accept edge, so the live inputs are used while still in IDLE.
    logic              acc_we;
    logic [ADDR_W-1:0] acc_idx;
    logic [15:0]       acc_dat;
    logic              acc_oor;
    logic              enter_resp;

    always_comb begin
        acc_we  = we_q;
        acc_idx = adr_q;
        acc_dat = dat_q;
        if (state == S_IDLE) begin
            acc_we  = WE_I;
            acc_idx = ADR_I[ADDR_W-1:0];
            acc_dat = DAT_I;
        end
    end

`ifdef DMEM_ERR_EN
    logic oor_q;
    logic oor_in;

    assign oor_in = |ADR_I[15:ADDR_W];

    always_comb begin
        acc_oor = oor_q;
        if (state == S_IDLE) begin
            acc_oor = oor_in;
        end
    end

    assign ACK_O = (state == S_RESP) && !oor_q;
    assign ERR_O = (state == S_RESP) && oor_q;
`else
    // Upper address bits are intentionally ignored; addresses wrap.
    logic unused_adr_hi;
    assign unused_adr_hi = ^ADR_I[15:ADDR_W];
    assign acc_oor       = 1'b0;
    assign ACK_O         = (state == S_RESP);
`endif

    assign enter_resp = (state_next == S_RESP) && !RST_I;
    assign dbg_state  = state;

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (STB_I) begin
                    state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                state_next = S_HOLD;
            end
            S_HOLD: begin
                if (!STB_I) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, request latch, wait counter, read data
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            we_q  <= 1'b0;
            adr_q <= '0;
            dat_q <= 16'h0000;
            DAT_O <= 16'h0000;
`ifdef DMEM_ERR_EN
            oor_q <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (state == S_IDLE && STB_I) begin
                we_q  <= WE_I;
                adr_q <= ADR_I[ADDR_W-1:0];
                dat_q <= DAT_I;
                cnt   <= 4'(WAIT_STATES);
`ifdef DMEM_ERR_EN
                oor_q <= oor_in;
`endif
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp && !acc_we && !acc_oor) begin
                DAT_O <= mem[acc_idx];
            end
        end
    end

    // RAM write port; no reset, contents survive RST_I. A reset before the
    // RESP edge keeps enter_resp low, so an aborted write is never committed.
    always_ff @(posedge CLK_I) begin
        if (enter_resp && acc_we && !acc_oor) begin
            mem[acc_idx] <= acc_dat;
        end
    end

endmodule

// File: tb/tb_dmem_wb_slave.sv
// ---------------------------------------------------------------------------
// tb_dmem_wb_slave
//   Four slaves with WAIT_STATES = 1, 0, 3, 15 share clock, reset and request
//   buses. Each slave has its own strobe. A table of accesses is applied
//   through one driver task. Hand-written sequences cover reset behaviour,
//   the held strobe, and a reset in the middle of an access.
// ---------------------------------------------------------------------------
module tb_dmem_wb_slave;

    localparam int N_DUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_s;
    logic [15:0] adr_s;
    logic [15:0] dat_s;
    logic        stb   [N_DUT];
    logic        ack   [N_DUT];
    logic [15:0] rdat  [N_DUT];
    logic [1:0]  dbg   [N_DUT];
`ifdef DMEM_ERR_EN
    logic        err   [N_DUT];
`endif

    int ws_tab [N_DUT] = '{1, 0, 3, 15};

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] exp_q [$];
    int          lat_q [$];
    bit          errx_q [$];
    logic [15:0] last_rd [N_DUT];

    // ---------------- clock / DUTs ----------------
    always #5 clk = ~clk;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        dmem_wb_slave #(
            .ADDR_W     (10),
            .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 3 : 15)
        ) dut (
            .CLK_I    (clk),
            .RST_I    (rst),
            .STB_I    (stb[g]),
            .WE_I     (we_s),
            .ADR_I    (adr_s),
            .DAT_I    (dat_s),
            .DAT_O    (rdat[g]),
            .ACK_O    (ack[g]),
`ifdef DMEM_ERR_EN
            .ERR_O    (err[g]),
`endif
            .dbg_state(dbg[g])
        );
    end

    function automatic bit err_of(int d);
`ifdef DMEM_ERR_EN
        return err[d];
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- checking ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One access on slave d. Called and returns just after a falling edge.
    task automatic access(int d, bit we, logic [15:0] adr, logic [15:0] dat,
                          logic [15:0] exp_rd, bit exp_err, bit drop);
        int          cyc;
        bit          got;
        logic [15:0] e_dat;
        int          e_lat;
        bit          e_err;
        exp_q.push_back(exp_rd);
        lat_q.push_back(ws_tab[d] + 1);
        errx_q.push_back(exp_err);
        we_s   = we;
        adr_s  = adr;
        dat_s  = dat;
        stb[d] = 1'b1;
        @(negedge clk);
        // Accepted; scramble the bus, which must now be ignored.
        adr_s = 16'($urandom);
        dat_s = 16'($urandom);
        we_s  = 1'($urandom_range(0, 1));
        if (drop) stb[d] = 1'b0;
        cyc = 1;
        while (!(ack[d] || err_of(d)) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        got   = ack[d] || err_of(d);
        e_dat = exp_q.pop_front();
        e_lat = lat_q.pop_front();
        e_err = errx_q.pop_front();
        check($sformatf("resp_seen d%0d", d), 32'(got), 32'd1);
        if (got) begin
            check($sformatf("latency d%0d", d), 32'(cyc), 32'(e_lat));
`ifdef DMEM_ERR_EN
            check($sformatf("err_pulse d%0d", d), 32'(err[d]), 32'(e_err));
            check($sformatf("ack_pulse d%0d", d), 32'(ack[d]), 32'(!e_err));
`endif
            if (!we && !e_err) begin
                check($sformatf("rd_data d%0d a%0h", d, adr), 32'(rdat[d]), 32'(e_dat));
                last_rd[d] = e_dat;
            end else begin
                check($sformatf("dat_hold d%0d", d), 32'(rdat[d]), 32'(last_rd[d]));
            end
        end
        @(negedge clk);
        check($sformatf("ack_width d%0d", d), 32'(ack[d] || err_of(d)), 32'd0);
        stb[d] = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          d;
        bit          we;
        logic [15:0] adr;
        logic [15:0] dat;
        logic [15:0] exp_rd;
        bit          exp_err;
        bit          drop;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(int d, bit we, logic [15:0] adr, logic [15:0] dat,
                                logic [15:0] exp_rd, bit exp_err, bit drop);
        vec_t v;
        v.d = d; v.we = we; v.adr = adr; v.dat = dat;
        v.exp_rd = exp_rd; v.exp_err = exp_err; v.drop = drop;
        return v;
    endfunction

    initial begin
        logic [15:0] r1, r2, r3, r5;
        bit          ee;
        int          cyc;
        int          acks;

        r1 = 16'($urandom); r2 = 16'($urandom);
        r3 = 16'($urandom); r5 = 16'($urandom);
`ifdef DMEM_ERR_EN
        ee = 1'b1;
`else
        ee = 1'b0;
`endif
        vecs[0]  = mk(0, 1, 16'h0005, 16'hBEEF, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 0, 16'h0005, 16'h0000, 16'hBEEF, 0, 0);
        vecs[2]  = mk(1, 1, 16'h03FF, r1,       16'h0000, 0, 0);
        vecs[3]  = mk(1, 0, 16'h03FF, 16'h0000, r1,       0, 0);
        vecs[4]  = mk(2, 1, 16'h0000, r2,       16'h0000, 0, 0);
        vecs[5]  = mk(2, 0, 16'h0000, 16'h0000, r2,       0, 0);
        vecs[6]  = mk(3, 1, 16'h0155, r3,       16'h0000, 0, 0);
        vecs[7]  = mk(3, 0, 16'h0155, 16'h0000, r3,       0, 0);
        vecs[8]  = mk(0, 1, 16'h0003, 16'h5A5A, 16'h0000, 0, 0);
        vecs[9]  = mk(0, 1, 16'h0403, 16'hA5A5, 16'h0000, ee, 0);
        vecs[10] = mk(0, 0, 16'h0003, 16'h0000, ee ? 16'h5A5A : 16'hA5A5, 0, 0);
        vecs[11] = mk(0, 0, 16'h0403, 16'h0000, 16'hA5A5, ee, 0);
        vecs[12] = mk(3, 1, 16'h0156, r5,       16'h0000, 0, 1);
        vecs[13] = mk(3, 0, 16'h0156, 16'h0000, r5,       0, 1);
        vecs[14] = mk(1, 0, 16'h07FF, 16'h0000, r1,       ee, 0);
        vecs[15] = mk(2, 0, 16'h0000, 16'h0000, r2,       0, 0);

        for (int i = 0; i < N_DUT; i++) begin
            stb[i]     = 1'b0;
            last_rd[i] = 16'h0000;
        end
        we_s  = 1'b0;
        adr_s = 16'h0000;
        dat_s = 16'h0000;

        // ---- reset with strobe held high: nothing may respond ----
        rst    = 1'b1;
        stb[0] = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < N_DUT; i++) begin
                check($sformatf("rst_ack d%0d", i), 32'(ack[i] || err_of(i)), 32'd0);
                check($sformatf("rst_dat d%0d", i), 32'(rdat[i]), 32'h0);
            end
        end
        rst = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack[0] && cyc < 40);
        check("first_ack_after_rst", 32'(cyc), 32'(ws_tab[0] + 1));
        @(negedge clk);
        check("first_ack_width", 32'(ack[0]), 32'd0);
        stb[0] = 1'b0;
        @(negedge clk);

        // ---- table ----
        for (int i = 0; i < 16; i++) begin
            access(vecs[i].d, vecs[i].we, vecs[i].adr, vecs[i].dat,
                   vecs[i].exp_rd, vecs[i].exp_err, vecs[i].drop);
        end

        // ---- held strobe: one ACK per request ----
        we_s   = 1'b0;
        adr_s  = 16'h0000;
        stb[2] = 1'b1;
        acks   = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack[2]) acks++;
        end
        check("held_stb_acks", 32'(acks), 32'd1);
        check("held_stb_data", 32'(rdat[2]), 32'(r2));
        stb[2] = 1'b0;
        @(negedge clk);
        stb[2] = 1'b1;
        acks   = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ack[2]) acks++;
        end
        check("reassert_acks", 32'(acks), 32'd1);
        stb[2] = 1'b0;
        @(negedge clk);

        // ---- reset during WAIT aborts the write ----
        access(2, 1, 16'h0010, 16'h0000, 16'h0000, 0, 0);
        we_s   = 1'b1;
        adr_s  = 16'h0010;
        dat_s  = 16'h1234;
        stb[2] = 1'b1;
        @(negedge clk);
        rst    = 1'b1;
        stb[2] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b0;
        acks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ack[2]) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        check("abort_dat_cleared d0", 32'(rdat[0]), 32'h0);
        for (int i = 0; i < N_DUT; i++) last_rd[i] = 16'h0000;
        access(2, 0, 16'h0010, 16'h0000, 16'h0000, 0, 0);
        access(0, 0, 16'h0005, 16'h0000, 16'hBEEF, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
